// File: rtl/frame_pkg.sv
// Shared types and constants for the frame packer and its helpers.
package frame_pkg;

  localparam int LEN_W  = 16;
  localparam int CNT_W  = 8;
  localparam int DATA_W = 32;

  localparam logic [15:0]       MAGIC        = 16'hA55A;
  localparam int                MAX_LEN_DEF  = 4096;
  localparam int                TIMEOUT_DEF  = 1024;
  localparam logic [DATA_W-1:0] PAD_WORD_DEF = 32'h0000_0000;

  // Header word 0: {magic, len}
  localparam int HDR0_MAGIC_LSB = 16;
  localparam int HDR0_LEN_LSB   = 0;
  // Header word 1: {frame_cnt, overrun_cnt, 7'b0, clamp}
  localparam int HDR1_FRAME_LSB = 16;
  localparam int HDR1_OVR_LSB   = 8;
  localparam int HDR1_CLAMP_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PAD     = 3'd4,
    S_TRAILER = 3'd5
  } state_t;

  function automatic logic [DATA_W-1:0] hdr0_word(input logic [15:0]      magic,
                                                  input logic [LEN_W-1:0] len);
    logic [DATA_W-1:0] w;
    w = '0;
    w[HDR0_MAGIC_LSB +: 16]  = magic;
    w[HDR0_LEN_LSB +: LEN_W] = len;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] hdr1_word(input logic [LEN_W-1:0] frame,
                                                  input logic [CNT_W-1:0] ovr,
                                                  input logic             clamp);
    logic [DATA_W-1:0] w;
    w = '0;
    w[HDR1_FRAME_LSB +: LEN_W] = frame;
    w[HDR1_OVR_LSB +: CNT_W]   = ovr;
    w[HDR1_CLAMP_BIT]          = clamp;
    return w;
  endfunction

endpackage

// File: rtl/frame_packer_sat_cnt8.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_cnt8
  import frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count one per pulse of i_inc until the counter is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/frame_packer.sv
// Frames each channel-buffer sync into: header0, header1, payload, checksum
// trailer, on a ready/valid output. Stalled payload is padded after a timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a sync pulse
// S_HDR0    | presenting {MAGIC, len} with o_sop
// S_HDR1    | presenting {frame_cnt, overrun_cnt, 7'b0, clamp}
// S_PAYLOAD | upstream words pass straight through and are summed
// S_PAD     | upstream stalled too long; PAD_WORD fills the remaining length
// S_TRAILER | presenting the checksum with o_eop
module frame_packer
  import frame_pkg::*;
#(
  parameter int                MAX_LEN  = MAX_LEN_DEF,
  parameter logic [15:0]       MAGIC    = frame_pkg::MAGIC,
  parameter int                TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] PAD_WORD = PAD_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sync_pulse,
  input  logic [LEN_W-1:0]  i_data_len,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  input  logic              i_ready,
  output logic              o_busy,
  output logic [LEN_W-1:0]  o_frame_cnt,
  output logic [CNT_W-1:0]  o_overrun_cnt,
  output logic [CNT_W-1:0]  o_timeout_cnt
);

  localparam int ST_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic              r_clamp;
  logic [LEN_W-1:0]  r_cnt;
  logic [ST_W-1:0]   r_stall;
  logic [DATA_W-1:0] r_csum;
  logic [DATA_W-1:0] r_hold;
  logic [LEN_W-1:0]  r_frame_cnt;

  logic              w_accept;
  logic              w_drop;
  logic              w_out_xfer;
  logic              w_in_xfer;
  logic              w_stall_tick;
  logic              w_to_pad;
  logic              w_clamp;
  logic [LEN_W-1:0]  w_len_clamped;
  logic [LEN_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] w_csum_data;
  logic [DATA_W-1:0] w_csum_pad;

  assign w_clamp       = (i_data_len > MAX_LEN_V);
  assign w_len_clamped = w_clamp ? MAX_LEN_V : i_data_len;
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_csum_data   = r_csum + i_data;
  assign w_csum_pad    = r_csum + PAD_WORD;

  // A sync not taken as a new frame while busy is counted as an overrun.
  assign w_drop = i_sync_pulse && (r_state != S_IDLE) && !w_accept;

  assign o_busy      = (r_state != S_IDLE);
  assign o_frame_cnt = r_frame_cnt;
  // Payload passes through combinationally; everything else comes from r_hold.
  assign o_data      = (r_state == S_PAYLOAD) ? i_data : r_hold;

  sat_cnt8 u_overrun_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_drop),
    .o_cnt (o_overrun_cnt)
  );

  sat_cnt8 u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_to_pad),
    .o_cnt (o_timeout_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nxt  = r_state;
    o_valid      = 1'b0;
    o_ready      = 1'b0;
    o_sop        = 1'b0;
    o_eop        = 1'b0;
    w_accept     = 1'b0;
    w_in_xfer    = 1'b0;
    w_stall_tick = 1'b0;
    w_to_pad     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_sync_pulse) begin
          w_accept    = 1'b1;
          w_state_nxt = S_HDR0;
        end
      end
      S_HDR0: begin
        o_valid = 1'b1;
        o_sop   = 1'b1;
        if (i_ready) w_state_nxt = S_HDR1;
      end
      S_HDR1: begin
        o_valid = 1'b1;
        if (i_ready) w_state_nxt = (r_len == '0) ? S_TRAILER : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        o_valid      = i_valid;
        o_ready      = i_ready;
        w_in_xfer    = i_valid && i_ready;
        // Only cycles where downstream could have taken a word count as stall.
        w_stall_tick = !i_valid && i_ready;
        if (w_in_xfer && (w_cnt_inc == r_len)) begin
          w_state_nxt = S_TRAILER;
        end else if (w_stall_tick && (r_stall == ST_W'(TIMEOUT - 1))) begin
          w_state_nxt = S_PAD;
          w_to_pad    = 1'b1;
        end
      end
      S_PAD: begin
        o_valid = 1'b1;
        if (i_ready && (w_cnt_inc == r_len)) w_state_nxt = S_TRAILER;
      end
      S_TRAILER: begin
        o_valid = 1'b1;
        o_eop   = 1'b1;
        if (i_ready) begin
          // A sync on the trailer transfer starts the next frame without a bubble.
          if (i_sync_pulse) begin
            w_accept    = 1'b1;
            w_state_nxt = S_HDR0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_out_xfer = o_valid && i_ready;
  end

  // Frame datapath: length latch, counters, checksum and the held output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_clamp     <= 1'b0;
      r_cnt       <= '0;
      r_stall     <= '0;
      r_csum      <= '0;
      r_hold      <= '0;
      r_frame_cnt <= '0;
    end else if (w_accept) begin
      r_len       <= w_len_clamped;
      r_clamp     <= w_clamp;
      r_cnt       <= '0;
      r_stall     <= '0;
      r_csum      <= '0;
      r_hold      <= hdr0_word(MAGIC, w_len_clamped);
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end else begin
      case (r_state)
        S_HDR0: begin
          // Snapshot taken here so later overruns cannot disturb a held header.
          if (w_out_xfer) r_hold <= hdr1_word(r_frame_cnt, o_overrun_cnt, r_clamp);
        end
        S_HDR1: begin
          if (w_out_xfer) r_hold <= r_csum;
        end
        S_PAYLOAD: begin
          if (w_in_xfer) begin
            r_csum  <= w_csum_data;
            r_cnt   <= w_cnt_inc;
            r_stall <= '0;
            if (w_state_nxt == S_TRAILER) r_hold <= w_csum_data;
          end else if (w_stall_tick) begin
            r_stall <= r_stall + 1'b1;
            if (w_to_pad) r_hold <= PAD_WORD;
          end
        end
        S_PAD: begin
          if (w_out_xfer) begin
            r_csum <= w_csum_pad;
            r_cnt  <= w_cnt_inc;
            if (w_state_nxt == S_TRAILER) r_hold <= w_csum_pad;
          end
        end
        S_TRAILER: begin
          if (w_out_xfer) r_hold <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Scoreboard bench for frame_packer: expected words are queued when a sync is
// driven and compared as the DUT hands words downstream.
module tb_frame_packer;
  import frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sync_pulse;
  logic [15:0] i_data_len;
  logic [31:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_sop;
  logic        o_eop;
  logic        i_ready;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_overrun_cnt;
  logic [7:0]  o_timeout_cnt;

  frame_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sync_pulse  (i_sync_pulse),
    .i_data_len    (i_data_len),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_sop         (o_sop),
    .o_eop         (o_eop),
    .i_ready       (i_ready),
    .o_busy        (o_busy),
    .o_frame_cnt   (o_frame_cnt),
    .o_overrun_cnt (o_overrun_cnt),
    .o_timeout_cnt (o_timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] up_q[$];
  int          total = 0;
  int          bad = 0;
  bit          rand_rdy = 1'b0;
  bit          rand_gap = 1'b0;
  logic [15:0] m_fc = '0;
  logic [7:0]  m_ovr = '0;
  int          rdy_hi = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, act, exp);
    end
  endtask

  // Model of one frame: headers, accepted payload (or pad), additive trailer.
  task automatic push_frame(input logic [15:0] len, input int n_up, input bit seq);
    int          l;
    logic        clamp;
    logic [31:0] w;
    logic [31:0] sum;
    clamp = (len > 16'd4096);
    l     = clamp ? 4096 : int'(len);
    m_fc  = m_fc + 16'd1;
    sb_q.push_back('{data: {16'hA55A, 16'(l)}, sop: 1'b1, eop: 1'b0});
    sb_q.push_back('{data: {m_fc, m_ovr, 7'b0, clamp}, sop: 1'b0, eop: 1'b0});
    sum = '0;
    for (int i = 0; i < n_up; i++) begin
      w = seq ? 32'(i + 1) : $urandom;
      up_q.push_back(w);
      if (i < l) begin
        sb_q.push_back('{data: w, sop: 1'b0, eop: 1'b0});
        sum = sum + w;
      end
    end
    for (int i = n_up; i < l; i++) sb_q.push_back('{data: 32'h0, sop: 1'b0, eop: 1'b0});
    sb_q.push_back('{data: sum, sop: 1'b0, eop: 1'b1});
  endtask

  task automatic send_sync(input logic [15:0] len, input int n_up, input bit seq);
    @(posedge clk); #1;
    i_sync_pulse = 1'b1;
    i_data_len   = len;
    push_frame(len, n_up, seq);
    @(posedge clk); #1;
    i_sync_pulse = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || o_busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, sb_q.size(), 0);
  endtask

  // Output monitor: scoreboard compare and hold-stability check.
  logic        p_hold = 1'b0;
  logic [31:0] p_data = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_hold = 1'b0;
      end else begin
        if (o_ready) rdy_hi++;
        if (p_hold) begin
          chk("hold_valid", o_valid, 1);
          chk("hold_data", o_data, p_data);
        end
        if (o_valid && i_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            chk("out_data", o_data, e.data);
            chk("out_sop", o_sop, e.sop);
            chk("out_eop", o_eop, e.eop);
          end
        end
        p_hold = o_valid && !i_ready;
        p_data = o_data;
      end
    end
  end

  // Upstream source: holds a presented word until it is taken.
  bit up_fire;
  initial begin
    i_valid = 1'b0;
    i_data  = '0;
    forever begin
      @(negedge clk);
      up_fire = i_valid && o_ready && rst_n;
      @(posedge clk); #1;
      if (up_fire && up_q.size() > 0) void'(up_q.pop_front());
      if (up_q.size() == 0) begin
        i_valid = 1'b0;
        i_data  = '0;
      end else begin
        if (!(i_valid && !up_fire)) i_valid = rand_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_data = up_q[0];
      end
    end
  end

  // Downstream sink ready.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=stuck want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n;
    i_sync_pulse = 1'b0;
    i_data_len   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_sop", o_sop, 0);
    chk("rst_eop", o_eop, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_data", o_data, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    chk("rst_overrun", o_overrun_cnt, 0);
    chk("rst_timeout", o_timeout_cnt, 0);

    // Basic 3-word frame.
    send_sync(16'd3, 3, 1'b1);
    wait_done("t1_done", 50);
    chk("t1_frame_cnt", o_frame_cnt, 1);

    // Empty frame: headers and trailer only.
    r0 = rdy_hi;
    send_sync(16'd0, 0, 1'b0);
    wait_done("t2_done", 50);
    chk("t2_ready_never", rdy_hi - r0, 0);

    // Oversized length clamps to 4096; extra upstream words stay unconsumed.
    send_sync(16'd5000, 4100, 1'b0);
    wait_done("t3_done", 5000);
    chk("t3_leftover", up_q.size(), 4);
    up_q.delete();
    repeat (2) @(posedge clk);

    // Random backpressure and upstream gaps.
    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 24);
      send_sync(16'(n), n, 1'b0);
      wait_done("t4_done", 400);
    end
    rand_rdy = 1'b0;
    rand_gap = 1'b0;
    repeat (2) @(posedge clk);

    // Upstream stalls after two words: padding completes the frame.
    chk("t5_timeout_before", o_timeout_cnt, 0);
    send_sync(16'd4, 2, 1'b0);
    wait_done("t5_done", 1500);
    chk("t5_timeout_cnt", o_timeout_cnt, 1);

    // Syncs in HDR1 and PAYLOAD are dropped, then a back-to-back sync on trailer.
    send_sync(16'd8, 8, 1'b0);
    @(posedge clk); #1; i_sync_pulse = 1'b1;
    @(posedge clk); #1; i_sync_pulse = 1'b0;
    @(posedge clk); #1; i_sync_pulse = 1'b1;
    @(posedge clk); #1; i_sync_pulse = 1'b0;
    m_ovr = m_ovr + 8'd2;
    chk("t6_overrun", o_overrun_cnt, 2);
    chk("t6_frame_cnt", o_frame_cnt, m_fc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(o_valid && o_eop && i_ready) && n < 100);
    chk("t6_eop_seen", {o_valid, o_eop}, 2'b11);
    i_sync_pulse = 1'b1;
    i_data_len   = 16'd2;
    push_frame(16'd2, 2, 1'b0);
    @(posedge clk); #1;
    i_sync_pulse = 1'b0;
    @(negedge clk);
    chk("t6_b2b_sop", {o_valid, o_sop}, 2'b11);
    chk("t6_b2b_frame_cnt", o_frame_cnt, m_fc);
    chk("t6_b2b_overrun", o_overrun_cnt, 2);
    wait_done("t6_done", 100);

    // Reset mid-frame aborts to reset values with no trailer.
    send_sync(16'd20, 20, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_data", o_data, 0);
    chk("mrst_frame_cnt", o_frame_cnt, 0);
    chk("mrst_overrun", o_overrun_cnt, 0);
    chk("mrst_timeout", o_timeout_cnt, 0);
    sb_q.delete();
    up_q.delete();
    m_fc  = '0;
    m_ovr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send_sync(16'd2, 2, 1'b0);
    wait_done("post_rst_done", 50);
    chk("post_rst_frame_cnt", o_frame_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
